// File: rtl/readout_frame_receiver.sv
// Readout frame receiver: assembles 15-byte words from an AXI byte stream, filters frames by MAC header,
// and emits hit words. Define RX_SEQ_CHECK_EN to add the packet-count gap counter (seq_err_count).
module readout_frame_receiver #(
  parameter int MAX_WORDS = 17
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [47:0]    local_mac,
  input  logic [7:0]     rx_axis_tdata,
  input  logic           rx_axis_tvalid,
  input  logic           rx_axis_tlast,
  output logic           rx_axis_tready,
  output logic           hit_valid,
  input  logic           hit_ready,
  output logic [2:0]     hit_channel,
  output logic [115:0]   hit_data,
  output logic [7:0]     channel_linked,
  output logic [79:0]    fifo_counters,
  output logic [7:0]     last_packet_count,
  output logic [15:0]    frame_ok_count,
  output logic [15:0]    frame_err_count
`ifdef RX_SEQ_CHECK_EN
  ,
  output logic [15:0]    seq_err_count
`endif
);

  localparam int WIDX_W = $clog2(MAX_WORDS + 2);
  localparam logic [WIDX_W-1:0] C_MAX_WORDS = WIDX_W'(MAX_WORDS);
  localparam logic [WIDX_W-1:0] C_WIDX_ONE  = WIDX_W'(1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HDR = 2'd1, S_DATA = 2'd2, S_DROP = 2'd3} state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t              r_state, w_state_nxt;
  logic [3:0]          r_byte_idx, w_byte_nxt;
  logic [WIDX_W-1:0]   r_word_idx, w_widx_nxt;
  logic [111:0]        r_shift, w_shift_nxt;
  logic                r_hit_valid;
  logic [2:0]          r_hit_channel;
  logic [115:0]        r_hit_data;
  logic [7:0]          r_channel_linked;
  logic [79:0]         r_fifo_counters;
  logic [7:0]          r_last_pkt;
  logic [15:0]         r_ok_cnt, r_err_cnt;

  logic                w_accept, w_word_done, w_hdr_valid, w_overflow, w_link_word;
  logic [119:0]        w_word;
  logic                w_ok_inc, w_err_inc, w_hdr_load, w_hit_load, w_link_load, w_cnt_load;

  assign rx_axis_tready    = ~r_hit_valid | hit_ready;
  assign hit_valid         = r_hit_valid;
  assign hit_channel       = r_hit_channel;
  assign hit_data          = r_hit_data;
  assign channel_linked    = r_channel_linked;
  assign fifo_counters     = r_fifo_counters;
  assign last_packet_count = r_last_pkt;
  assign frame_ok_count    = r_ok_cnt;
  assign frame_err_count   = r_err_cnt;

  // Byte acceptance, word classification and next-state decode
  always_comb begin
    w_accept    = rx_axis_tvalid & rx_axis_tready;
    w_word      = {r_shift, rx_axis_tdata};
    w_word_done = (r_byte_idx == 4'd14);
    w_hdr_valid = ((w_word[119:72] == local_mac) || (w_word[119:72] == 48'hFFFF_FFFF_FFFF)) &&
                  (w_word[15:0] == 16'h00FF);
    w_overflow  = (r_word_idx >= C_MAX_WORDS);
    w_link_word = (w_word[119:16] == 104'd0) && (w_word[15:12] == 4'hF);
    w_state_nxt = r_state;
    w_byte_nxt  = r_byte_idx;
    w_widx_nxt  = r_word_idx;
    w_shift_nxt = r_shift;
    w_ok_inc    = 1'b0;
    w_err_inc   = 1'b0;
    w_hdr_load  = 1'b0;
    w_hit_load  = 1'b0;
    w_link_load = 1'b0;
    w_cnt_load  = 1'b0;
    if (w_accept) begin
      case (r_state)
        S_DROP: begin
          if (rx_axis_tlast) begin
            w_err_inc   = 1'b1;
            w_state_nxt = S_IDLE;
            w_byte_nxt  = 4'd0;
            w_widx_nxt  = '0;
          end else begin
            w_state_nxt = S_DROP;
          end
        end
        default: begin
          if (rx_axis_tlast && !w_word_done) begin
            w_err_inc   = 1'b1;
            w_state_nxt = S_IDLE;
            w_byte_nxt  = 4'd0;
            w_widx_nxt  = '0;
          end else if (w_word_done) begin
            w_byte_nxt = 4'd0;
            w_widx_nxt = r_word_idx + C_WIDX_ONE;
            if (w_overflow) begin
              w_widx_nxt = '0;
              if (rx_axis_tlast) begin
                w_err_inc   = 1'b1;
                w_state_nxt = S_IDLE;
              end else begin
                w_state_nxt = S_DROP;
              end
            end else if (r_state == S_DATA) begin
              w_hit_load  = w_word[119];
              w_link_load = ~w_word[119] & w_link_word;
              w_cnt_load  = ~w_word[119] & ~w_link_word & (w_word[39:0] == 40'hFF_FFFF_FFFF);
              if (rx_axis_tlast) begin
                w_ok_inc    = 1'b1;
                w_state_nxt = S_IDLE;
                w_widx_nxt  = '0;
              end else begin
                w_state_nxt = S_DATA;
              end
            end else if (w_hdr_valid) begin
              w_hdr_load = 1'b1;
              if (rx_axis_tlast) begin
                w_ok_inc    = 1'b1;
                w_state_nxt = S_IDLE;
                w_widx_nxt  = '0;
              end else begin
                w_state_nxt = S_DATA;
              end
            end else begin
              // Rejected header: a frame ending here is already complete, otherwise drain it
              if (rx_axis_tlast) begin
                w_err_inc   = 1'b1;
                w_state_nxt = S_IDLE;
                w_widx_nxt  = '0;
              end else begin
                w_state_nxt = S_DROP;
              end
            end
          end else begin
            w_shift_nxt = w_word[111:0];
            w_byte_nxt  = r_byte_idx + 4'd1;
            if (r_state == S_IDLE) begin
              w_state_nxt = S_HDR;
            end else begin
              w_state_nxt = r_state;
            end
          end
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // FSM state and byte/word position
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_byte_idx <= 4'd0;
      r_word_idx <= '0;
      r_shift    <= 112'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_byte_idx <= w_byte_nxt;
      r_word_idx <= w_widx_nxt;
      r_shift    <= w_shift_nxt;
    end
  end

  // Hit output holding register; loads only when the previous hit is gone or leaving
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hit_valid   <= 1'b0;
      r_hit_channel <= 3'd0;
      r_hit_data    <= 116'd0;
    end else if (w_hit_load) begin
      r_hit_valid   <= 1'b1;
      r_hit_channel <= w_word[118:116];
      r_hit_data    <= w_word[115:0];
    end else if (hit_ready) begin
      r_hit_valid   <= 1'b0;
    end
  end

  // Latched status words and frame counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_channel_linked <= 8'd0;
      r_fifo_counters  <= 80'd0;
      r_last_pkt       <= 8'd0;
      r_ok_cnt         <= 16'd0;
      r_err_cnt        <= 16'd0;
    end else begin
      if (w_link_load) r_channel_linked <= w_word[7:0];
      if (w_cnt_load)  r_fifo_counters  <= w_word[119:40];
      if (w_hdr_load)  r_last_pkt       <= w_word[23:16];
      if (w_ok_inc)    r_ok_cnt         <= sat_inc(r_ok_cnt);
      if (w_err_inc)   r_err_cnt        <= sat_inc(r_err_cnt);
    end
  end

`ifdef RX_SEQ_CHECK_EN
  logic        r_seq_seen;
  logic [15:0] r_seq_err;

  assign seq_err_count = r_seq_err;

  // Packet-count continuity; the first header after reset has no predecessor
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_seq_seen <= 1'b0;
      r_seq_err  <= 16'd0;
    end else if (w_hdr_load) begin
      r_seq_seen <= 1'b1;
      if (r_seq_seen && (w_word[23:16] != (r_last_pkt + 8'd1))) begin
        r_seq_err <= sat_inc(r_seq_err);
      end
    end
  end
`endif

endmodule

// File: tb/tb_readout_frame_receiver.sv
// Scoreboard bench for readout_frame_receiver: frames are built as byte queues, expected hits queued.
module tb_readout_frame_receiver;

  localparam logic [47:0] LMAC = 48'h02_00_00_00_00_11;
  localparam logic [47:0] SMAC = 48'h02_00_00_00_00_AA;
  localparam int          MAXW = 17;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   rx_axis_tdata;
  logic         rx_axis_tvalid, rx_axis_tlast, rx_axis_tready;
  logic         hit_valid, hit_ready;
  logic [2:0]   hit_channel;
  logic [115:0] hit_data;
  logic [7:0]   channel_linked, last_packet_count;
  logic [79:0]  fifo_counters;
  logic [15:0]  frame_ok_count, frame_err_count;
`ifdef RX_SEQ_CHECK_EN
  logic [15:0]  seq_err_count;
`endif

  typedef struct packed {logic [2:0] ch; logic [115:0] d;} hit_t;
  hit_t       exp_q[$];
  logic [7:0] tx_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int bytes_sent = 0;

  always #5 clk = ~clk;

  readout_frame_receiver #(.MAX_WORDS(MAXW)) dut (
    .clk(clk), .reset(reset), .local_mac(LMAC),
    .rx_axis_tdata(rx_axis_tdata), .rx_axis_tvalid(rx_axis_tvalid),
    .rx_axis_tlast(rx_axis_tlast), .rx_axis_tready(rx_axis_tready),
    .hit_valid(hit_valid), .hit_ready(hit_ready), .hit_channel(hit_channel), .hit_data(hit_data),
    .channel_linked(channel_linked), .fifo_counters(fifo_counters),
    .last_packet_count(last_packet_count), .frame_ok_count(frame_ok_count),
    .frame_err_count(frame_err_count)
`ifdef RX_SEQ_CHECK_EN
    , .seq_err_count(seq_err_count)
`endif
  );

  // Scoreboard: every hit handshake is popped against the queue of expected hits
  always begin
    @(negedge clk);
    #1;
    if (reset && hit_valid && hit_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_hit: got ch=%0d data=%h, expected none", hit_channel, hit_data);
      end else begin
        hit_t e;
        e = exp_q.pop_front();
        if (hit_channel !== e.ch || hit_data !== e.d) begin
          n_fail++;
          $display("FAIL hit_word: got ch=%0d data=%h, expected ch=%0d data=%h",
                   hit_channel, hit_data, e.ch, e.d);
        end
      end
    end
  end

  function automatic logic [119:0] hdr(input logic [47:0] dst, input logic [7:0] pkt);
    return {dst, SMAC, pkt, 8'h00, 8'hFF};
  endfunction

  function automatic logic [119:0] link_w(input logic [7:0] v);
    return {104'd0, 4'hF, 4'h0, v};
  endfunction

  task automatic push_word(input logic [119:0] w);
    for (int i = 14; i >= 0; i--) tx_q.push_back(w[i*8 +: 8]);
  endtask

  task automatic push_hit(input logic [2:0] ch, input logic [115:0] d, input bit expect_out);
    hit_t h;
    push_word({1'b1, ch, d});
    h.ch = ch;
    h.d  = d;
    if (expect_out) exp_q.push_back(h);
  endtask

  task automatic send_bytes(input int n, input bit with_last);
    for (int i = 0; i < n; i++) begin
      int guard;
      @(negedge clk);
      rx_axis_tvalid = 1'b1;
      rx_axis_tdata  = tx_q[i];
      rx_axis_tlast  = with_last && (i == n - 1);
      #1;
      guard = 0;
      while (!rx_axis_tready && guard < 1000) begin
        @(negedge clk);
        #1;
        guard++;
      end
      if (guard >= 1000) begin
        n_checks++;
        n_fail++;
        $display("FAIL tready_timeout: tready stayed 0 for %0d cycles, expected 1", guard);
      end
      @(posedge clk);
      bytes_sent++;
    end
    tx_q.delete();
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    rx_axis_tvalid = 1'b0;
    rx_axis_tlast  = 1'b0;
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    rx_axis_tvalid = 1'b0;
    rx_axis_tlast  = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    rx_axis_tvalid = 1'b0;
    rx_axis_tlast  = 1'b0;
    rx_axis_tdata  = 8'h00;
    hit_ready      = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (rx_axis_tready !== 1'b1 || hit_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_handshake: got tready=%b hit_valid=%b, expected 1/0", rx_axis_tready, hit_valid);
    end
    n_checks++;
    if (hit_channel !== 3'd0 || hit_data !== 116'd0 || channel_linked !== 8'd0 ||
        fifo_counters !== 80'd0 || last_packet_count !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_regs: got ch=%0d data=%h link=%h fifo=%h pkt=%h, expected all 0",
               hit_channel, hit_data, channel_linked, fifo_counters, last_packet_count);
    end
    n_checks++;
    if (frame_ok_count !== 16'd0 || frame_err_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_counters: got ok=%0d err=%0d, expected 0/0", frame_ok_count, frame_err_count);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_basic_frame();
    int base;
    push_word(hdr(LMAC, 8'h05));
    push_hit(3'd2, 116'h1234, 1'b1);
    push_word(link_w(8'hA5));
    base = bytes_sent;
    fork
      send_bytes(45, 1'b1);
      begin
        int g;
        g = 0;
        while (bytes_sent < base + 30 && g < 500) begin
          @(negedge clk);
          g++;
        end
        #1;
        n_checks++;
        if (hit_valid !== 1'b1 || hit_channel !== 3'd2) begin
          n_fail++;
          $display("FAIL hit_latency: got hit_valid=%b ch=%0d one cycle after byte 30, expected 1/2",
                   hit_valid, hit_channel);
        end
      end
    join
    idle(3);
    n_checks++;
    if (channel_linked !== 8'hA5 || last_packet_count !== 8'h05) begin
      n_fail++;
      $display("FAIL basic_status: got link=%h pkt=%h, expected a5/05", channel_linked, last_packet_count);
    end
    n_checks++;
    if (frame_ok_count !== 16'd1 || frame_err_count !== 16'd0) begin
      n_fail++;
      $display("FAIL basic_counts: got ok=%0d err=%0d, expected 1/0", frame_ok_count, frame_err_count);
    end
  endtask

  task automatic test_bad_dst();
    push_word(hdr(48'h02_00_00_00_00_99, 8'h06));
    push_hit(3'd2, 116'h1234, 1'b0);
    push_word(link_w(8'h3C));
    send_bytes(45, 1'b1);
    idle(3);
    n_checks++;
    if (frame_err_count !== 16'd1 || channel_linked !== 8'hA5 || last_packet_count !== 8'h05) begin
      n_fail++;
      $display("FAIL bad_dst: got err=%0d link=%h pkt=%h, expected 1/a5/05",
               frame_err_count, channel_linked, last_packet_count);
    end
    push_word(hdr(48'hFFFF_FFFF_FFFF, 8'h07));
    push_hit(3'd5, 116'hABCD_0000_1111, 1'b1);
    push_word(link_w(8'h5A));
    send_bytes(45, 1'b1);
    idle(3);
    n_checks++;
    if (frame_ok_count !== 16'd2 || channel_linked !== 8'h5A || last_packet_count !== 8'h07) begin
      n_fail++;
      $display("FAIL after_bad_dst: got ok=%0d link=%h pkt=%h, expected 2/5a/07",
               frame_ok_count, channel_linked, last_packet_count);
    end
  endtask

  task automatic test_short_frame();
    push_word(hdr(LMAC, 8'h08));
    push_hit(3'd1, 116'h7777, 1'b0);
    send_bytes(22, 1'b1);
    idle(3);
    n_checks++;
    if (frame_err_count !== 16'd2 || frame_ok_count !== 16'd2 || hit_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL short_frame: got err=%0d ok=%0d hv=%b, expected 2/2/0",
               frame_err_count, frame_ok_count, hit_valid);
    end
    push_word(hdr(LMAC, 8'h09));
    send_bytes(8, 1'b1);
    idle(2);
    n_checks++;
    if (frame_err_count !== 16'd3 || last_packet_count !== 8'h08) begin
      n_fail++;
      $display("FAIL hdr_short: got err=%0d pkt=%h, expected 3/08", frame_err_count, last_packet_count);
    end
  endtask

  task automatic test_back_to_back();
    push_word(hdr(LMAC, 8'h10));
    push_hit(3'd3, 116'h0000_0000_0000_BEEF, 1'b1);
    send_bytes(30, 1'b1);
    push_word(hdr(LMAC, 8'h11));
    push_hit(3'd4, 116'hFFFF_0000_0000_CAFE, 1'b1);
    send_bytes(30, 1'b1);
    idle(3);
    n_checks++;
    if (frame_ok_count !== 16'd4 || last_packet_count !== 8'h11 || frame_err_count !== 16'd3) begin
      n_fail++;
      $display("FAIL back_to_back: got ok=%0d pkt=%h err=%0d, expected 4/11/3",
               frame_ok_count, last_packet_count, frame_err_count);
    end
  endtask

  task automatic test_stall();
    bit stall_bad;
    stall_bad = 1'b0;
    push_word(hdr(LMAC, 8'h12));
    push_hit(3'd0, 116'h1, 1'b1);
    push_hit(3'd6, 116'h2222_2222, 1'b1);
    push_hit(3'd7, 116'h3333_3333_3333, 1'b1);
    push_word({80'h1234_5678_9ABC_DEF0_1357, 40'hFF_FFFF_FFFF});
    @(negedge clk);
    hit_ready = 1'b0;
    fork
      send_bytes(75, 1'b1);
      begin
        int g;
        g = 0;
        while (hit_valid !== 1'b1 && g < 500) begin
          @(negedge clk);
          #1;
          g++;
        end
        for (int c = 0; c < 20; c++) begin
          @(negedge clk);
          #1;
          if (rx_axis_tready !== 1'b0 || hit_valid !== 1'b1) stall_bad = 1'b1;
        end
        n_checks++;
        if (stall_bad) begin
          n_fail++;
          $display("FAIL stall_tready: got tready=%b hv=%b during stall, expected 0/1",
                   rx_axis_tready, hit_valid);
        end
        @(negedge clk);
        hit_ready = 1'b1;
      end
    join
    idle(4);
    n_checks++;
    if (fifo_counters !== 80'h1234_5678_9ABC_DEF0_1357 || frame_ok_count !== 16'd5) begin
      n_fail++;
      $display("FAIL stall_result: got fifo=%h ok=%0d, expected 123456789abcdef01357/5",
               fifo_counters, frame_ok_count);
    end
  endtask

  task automatic test_max_words();
    push_word(hdr(LMAC, 8'h20));
    for (int w = 1; w < MAXW; w++) push_word(120'd0);
    send_bytes(MAXW * 15, 1'b1);
    idle(2);
    n_checks++;
    if (frame_ok_count !== 16'd6 || frame_err_count !== 16'd3) begin
      n_fail++;
      $display("FAIL max_words_ok: got ok=%0d err=%0d, expected 6/3", frame_ok_count, frame_err_count);
    end
    push_word(hdr(LMAC, 8'h21));
    push_hit(3'd1, 116'h4242, 1'b1);
    for (int w = 2; w <= MAXW; w++) push_word(120'd0);
    for (int b = 0; b < 5; b++) tx_q.push_back(8'h5A);
    send_bytes((MAXW + 1) * 15 + 5, 1'b1);
    idle(2);
    n_checks++;
    if (frame_ok_count !== 16'd6 || frame_err_count !== 16'd4) begin
      n_fail++;
      $display("FAIL overflow: got ok=%0d err=%0d, expected 6/4", frame_ok_count, frame_err_count);
    end
  endtask

  task automatic test_reset_mid_frame();
    push_word(hdr(LMAC, 8'h40));
    push_word(link_w(8'h77));
    send_bytes(30, 1'b0);
    @(negedge clk);
    #1;
    n_checks++;
    if (channel_linked !== 8'h77) begin
      n_fail++;
      $display("FAIL mid_link: got link=%h, expected 77", channel_linked);
    end
    reset = 1'b0;
    rx_axis_tvalid = 1'b0;
    #2;
    n_checks++;
    if (channel_linked !== 8'd0 || last_packet_count !== 8'd0 || frame_ok_count !== 16'd0 ||
        frame_err_count !== 16'd0 || rx_axis_tready !== 1'b1 || hit_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got link=%h pkt=%h ok=%0d err=%0d tready=%b hv=%b, expected 0/0/0/0/1/0",
               channel_linked, last_packet_count, frame_ok_count, frame_err_count, rx_axis_tready, hit_valid);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    push_word(hdr(LMAC, 8'h09));
    push_hit(3'd3, 116'h9999, 1'b1);
    send_bytes(30, 1'b1);
    idle(3);
    n_checks++;
    if (frame_ok_count !== 16'd1 || frame_err_count !== 16'd0 || last_packet_count !== 8'h09) begin
      n_fail++;
      $display("FAIL after_reset: got ok=%0d err=%0d pkt=%h, expected 1/0/09",
               frame_ok_count, frame_err_count, last_packet_count);
    end
  endtask

`ifdef RX_SEQ_CHECK_EN
  task automatic test_seq_check();
    logic [7:0] pkts [4];
    pkts = '{8'hFE, 8'hFF, 8'h00, 8'h02};
    do_reset();
    for (int f = 0; f < 4; f++) begin
      push_word(hdr(LMAC, pkts[f]));
      push_word(120'd0);
      send_bytes(30, 1'b1);
    end
    idle(3);
    n_checks++;
    if (seq_err_count !== 16'd1 || frame_ok_count !== 16'd4) begin
      n_fail++;
      $display("FAIL seq_err: got seq=%0d ok=%0d, expected 1/4", seq_err_count, frame_ok_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_frame();
    test_bad_dst();
    test_short_frame();
    test_back_to_back();
    test_stall();
    test_max_words();
    test_reset_mid_frame();
`ifdef RX_SEQ_CHECK_EN
    test_seq_check();
`endif
    idle(3);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL hits_missing: got %0d undelivered hits, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
